// File: rtl/l1b_buyruk_onbellegi_pkg.sv
// Shared constants and FSM state encoding for the L1 instruction cache.
package l1b_buyruk_onbellegi_pkg;

  localparam int unsigned PS_BIT           = 32;
  localparam int unsigned L1B_SATIR_SAYISI = 64;
  localparam int unsigned L1B_SATIR_KELIME = 4;

  typedef enum logic [2:0] {
    L1B_HAZIR,
    L1B_KONTROL,
    L1B_BELLEK_ISTEK,
    L1B_BELLEK_YANIT,
    L1B_YANIT
  } l1b_durum_e;

endpackage

// File: rtl/l1b_sram.sv
// Simple dual-port array: one synchronous-read port, one write port.
module l1b_sram #(
  parameter int unsigned DERINLIK = 64,
  parameter int unsigned GENISLIK = 32
) (
  input  logic                        clk_i,
  input  logic [$clog2(DERINLIK)-1:0] okuma_adres_i,
  output logic [GENISLIK-1:0]         okuma_veri_o,
  input  logic                        yazma_en_i,
  input  logic [$clog2(DERINLIK)-1:0] yazma_adres_i,
  input  logic [GENISLIK-1:0]         yazma_veri_i
);

  logic [GENISLIK-1:0] bellek [DERINLIK];

  always_ff @(posedge clk_i) begin
    if (yazma_en_i) bellek[yazma_adres_i] <= yazma_veri_i;
    okuma_veri_o <= bellek[okuma_adres_i];
  end

endmodule

// File: rtl/l1b_buyruk_onbellegi.sv
// Direct-mapped L1 instruction cache; one outstanding request, word-by-word line refill.
module l1b_buyruk_onbellegi
  import l1b_buyruk_onbellegi_pkg::*;
#(
  parameter int unsigned SATIR_SAYISI = L1B_SATIR_SAYISI,
  parameter int unsigned SATIR_KELIME = L1B_SATIR_KELIME
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [PS_BIT-1:0] l1b_istek_adres_i,
  input  logic              l1b_istek_gecerli_i,
  output logic              l1b_istek_hazir_o,
  output logic [31:0]       l1b_buyruk_o,
  output logic              l1b_buyruk_gecerli_o,
  input  logic              l1b_buyruk_hazir_i,
  input  logic              l1b_bosalt_i,
  input  logic              l1b_gecersiz_kil_i,
  output logic [PS_BIT-1:0] bellek_istek_adres_o,
  output logic              bellek_istek_gecerli_o,
  input  logic              bellek_istek_hazir_i,
  input  logic [31:0]       bellek_yanit_veri_i,
  input  logic              bellek_yanit_gecerli_i
);

  localparam int unsigned KB  = $clog2(SATIR_KELIME);
  localparam int unsigned OFS = KB + 2;
  localparam int unsigned IB  = $clog2(SATIR_SAYISI);
  localparam int unsigned TB  = PS_BIT - OFS - IB;

  l1b_durum_e            durum_q;
  logic [PS_BIT-1:2]     adres_q;
  logic [SATIR_SAYISI-1:0] gecerli_q;
  logic [KB-1:0]         sayac_q;
  logic                  yanit_bekliyor_q;
  logic                  olduruldu_q;
  logic                  gk_bekliyor_q;
  logic [31:0]           yanit_q;

  logic [TB-1:0]         tag_okunan;
  logic [31:0]           veri_okunan;
  logic                  kabul, isabet, son_vurus, gk_herhangi, gk_uygula;
  logic                  adres_unused;

  assign adres_unused = ^l1b_istek_adres_i[1:0];

  wire [IB-1:0] istek_idx = l1b_istek_adres_i[OFS +: IB];
  wire [KB-1:0] istek_kel = l1b_istek_adres_i[2 +: KB];
  wire [IB-1:0] q_idx     = adres_q[OFS +: IB];
  wire [KB-1:0] q_kel     = adres_q[2 +: KB];
  wire [TB-1:0] q_tag     = adres_q[PS_BIT-1 -: TB];

  assign kabul       = l1b_istek_gecerli_i && l1b_istek_hazir_o;
  assign isabet      = gecerli_q[q_idx] && (tag_okunan == q_tag);
  assign son_vurus   = (sayac_q == KB'(SATIR_KELIME - 1));
  assign gk_herhangi = l1b_gecersiz_kil_i || gk_bekliyor_q;
  assign gk_uygula   = (durum_q == L1B_HAZIR) && !yanit_bekliyor_q && gk_herhangi;

  wire yazma_en = (durum_q == L1B_BELLEK_YANIT) && bellek_yanit_gecerli_i;

  // Arrays read the incoming index on acceptance so the compare lands in KONTROL.
  l1b_sram #(.DERINLIK(SATIR_SAYISI), .GENISLIK(TB)) u_tag (
    .clk_i        (clk_i),
    .okuma_adres_i(kabul ? istek_idx : q_idx),
    .okuma_veri_o (tag_okunan),
    .yazma_en_i   (yazma_en && son_vurus),
    .yazma_adres_i(q_idx),
    .yazma_veri_i (q_tag)
  );

  l1b_sram #(.DERINLIK(SATIR_SAYISI * SATIR_KELIME), .GENISLIK(32)) u_veri (
    .clk_i        (clk_i),
    .okuma_adres_i(kabul ? {istek_idx, istek_kel} : {q_idx, q_kel}),
    .okuma_veri_o (veri_okunan),
    .yazma_en_i   (yazma_en),
    .yazma_adres_i({q_idx, sayac_q}),
    .yazma_veri_i (bellek_yanit_veri_i)
  );

  assign bellek_istek_gecerli_o = (durum_q == L1B_BELLEK_ISTEK);
  assign bellek_istek_adres_o   = {adres_q[PS_BIT-1:OFS], OFS'(0)};

  always_comb begin
    l1b_istek_hazir_o    = 1'b0;
    l1b_buyruk_gecerli_o = 1'b0;
    l1b_buyruk_o         = yanit_q;
    case (durum_q)
      L1B_HAZIR: begin
        l1b_istek_hazir_o    = !gk_herhangi && (!yanit_bekliyor_q || l1b_buyruk_hazir_i);
        l1b_buyruk_gecerli_o = yanit_bekliyor_q;
      end
      L1B_KONTROL: begin
        l1b_buyruk_gecerli_o = isabet;
        l1b_buyruk_o         = veri_okunan;
        l1b_istek_hazir_o    = isabet && l1b_buyruk_hazir_i && !gk_herhangi;
      end
      L1B_YANIT: l1b_buyruk_gecerli_o = 1'b1;
      default: ;
    endcase
    if (!rstn_i) begin
      l1b_istek_hazir_o    = 1'b0;
      l1b_buyruk_gecerli_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      durum_q          <= L1B_HAZIR;
      adres_q          <= '0;
      gecerli_q        <= '0;
      sayac_q          <= '0;
      yanit_bekliyor_q <= 1'b0;
      olduruldu_q      <= 1'b0;
      gk_bekliyor_q    <= 1'b0;
      yanit_q          <= '0;
    end else begin
      if (kabul) adres_q <= l1b_istek_adres_i[PS_BIT-1:2];
      if (l1b_gecersiz_kil_i) gk_bekliyor_q <= 1'b1;
      if (gk_uygula) begin
        gecerli_q     <= '0;
        gk_bekliyor_q <= 1'b0;
      end
      case (durum_q)
        L1B_HAZIR: begin
          if (yanit_bekliyor_q && (l1b_buyruk_hazir_i || l1b_bosalt_i)) yanit_bekliyor_q <= 1'b0;
          if (kabul) durum_q <= L1B_KONTROL;
        end
        L1B_KONTROL: begin
          if (isabet) begin
            // An untaken hit parks in the holding register unless the pipe is flushing.
            if (!l1b_buyruk_hazir_i && !l1b_bosalt_i) begin
              yanit_bekliyor_q <= 1'b1;
              yanit_q          <= veri_okunan;
            end
            durum_q <= kabul ? L1B_KONTROL : L1B_HAZIR;
          end else begin
            durum_q     <= L1B_BELLEK_ISTEK;
            olduruldu_q <= l1b_bosalt_i;
            sayac_q     <= '0;
          end
        end
        L1B_BELLEK_ISTEK: begin
          if (l1b_bosalt_i) olduruldu_q <= 1'b1;
          if (bellek_istek_hazir_i) durum_q <= L1B_BELLEK_YANIT;
        end
        L1B_BELLEK_YANIT: begin
          if (l1b_bosalt_i) olduruldu_q <= 1'b1;
          if (bellek_yanit_gecerli_i) begin
            sayac_q <= sayac_q + KB'(1);
            if (sayac_q == q_kel) yanit_q <= bellek_yanit_veri_i;
            if (son_vurus) begin
              gecerli_q[q_idx] <= 1'b1;
              olduruldu_q      <= 1'b0;
              durum_q <= (olduruldu_q || l1b_bosalt_i) ? L1B_HAZIR : L1B_YANIT;
            end
          end
        end
        L1B_YANIT: begin
          if (l1b_buyruk_hazir_i || l1b_bosalt_i) durum_q <= L1B_HAZIR;
        end
        default: durum_q <= L1B_HAZIR;
      endcase
    end
  end

endmodule
